// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl
// Brief    : Time-multiplexed 7-segment scan controller with inter-digit
//            blanking, leading-zero suppression and double-buffered digits.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16,
    parameter int LZ_SUPPRESS  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    output logic [3:0]              bindata,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int c_CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(REFRESH_DIV - 1);
    localparam logic [c_IW-1:0] c_IDX_LAST = c_IW'(NUM_DIGITS - 1);

    localparam logic [0:0] c_ST_BLANK = 1'b0;
    localparam logic [0:0] c_ST_DRIVE = 1'b1;

    logic [c_CW-1:0]         r_cnt;
    logic [c_IW-1:0]         r_idx;
    logic [0:0]              r_state;
    logic [4*NUM_DIGITS-1:0] r_shadow_dig;
    logic [NUM_DIGITS-1:0]   r_shadow_dp;
    logic [4*NUM_DIGITS-1:0] r_active_dig;
    logic [NUM_DIGITS-1:0]   r_active_dp;
    logic [3:0]              r_bindata;
    logic [NUM_DIGITS-1:0]   r_anode;
    logic                    r_dp;
    logic                    r_frame_done;

    logic                    w_slot_end;
    logic                    w_wrap;
    logic [c_CW-1:0]         w_cnt_nxt;
    logic [c_IW-1:0]         w_idx_nxt;
    logic [0:0]              w_state_nxt;
    logic                    w_past_blank;
    logic [4*NUM_DIGITS-1:0] w_active_dig_nxt;
    logic [NUM_DIGITS-1:0]   w_active_dp_nxt;
    logic [3:0]              w_nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   w_supp;
    logic [NUM_DIGITS-1:0]   w_sel;
    logic                    w_lit;

    assign w_slot_end = (r_cnt == c_CNT_LAST);
    assign w_wrap     = w_slot_end && (r_idx == c_IDX_LAST);
    assign w_cnt_nxt  = w_slot_end ? '0 : r_cnt + 1'b1;
    assign w_idx_nxt  = w_wrap ? '0 : (w_slot_end ? r_idx + 1'b1 : r_idx);

    // A load landing on the wrap cycle bypasses the shadow so the new frame
    // starts with the freshest data.
    assign w_active_dig_nxt = w_wrap ? (load ? digits_in : r_shadow_dig) : r_active_dig;
    assign w_active_dp_nxt  = w_wrap ? (load ? dp_in : r_shadow_dp) : r_active_dp;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign w_nib[gi] = w_active_dig_nxt[4*gi +: 4];
    end

    generate
        if (LZ_SUPPRESS != 0 && NUM_DIGITS > 1) begin : g_lz
            // w_zero_hi[i]: digits i..top are all zero with no decimal point.
            logic [NUM_DIGITS-1:1] w_zero_hi;
            assign w_zero_hi[NUM_DIGITS-1] = (w_nib[NUM_DIGITS-1] == 4'h0) &&
                                             !w_active_dp_nxt[NUM_DIGITS-1];
            for (genvar gi = 1; gi < NUM_DIGITS-1; gi++) begin : g_chain
                assign w_zero_hi[gi] = w_zero_hi[gi+1] && (w_nib[gi] == 4'h0) &&
                                       !w_active_dp_nxt[gi];
            end
            assign w_supp = {w_zero_hi, 1'b0};
        end else begin : g_no_lz
            assign w_supp = '0;
        end
    endgenerate

    generate
        if (BLANK_CYCLES > 0) begin : g_blank
            assign w_past_blank = (w_cnt_nxt >= c_CW'(BLANK_CYCLES));
        end else begin : g_no_blank
            assign w_past_blank = 1'b1;
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_BLANK: if (w_past_blank) w_state_nxt = c_ST_DRIVE;
            c_ST_DRIVE: if (w_slot_end && (BLANK_CYCLES > 0)) w_state_nxt = c_ST_BLANK;
        endcase
    end

    // Outputs are computed from next-cycle cnt/idx so they line up with the
    // registered counters.
    assign w_sel = NUM_DIGITS'(1) << w_idx_nxt;
    assign w_lit = (w_state_nxt == c_ST_DRIVE) && !w_supp[w_idx_nxt];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_state      <= c_ST_BLANK;
            r_shadow_dig <= '0;
            r_shadow_dp  <= '0;
            r_active_dig <= '0;
            r_active_dp  <= '0;
            r_bindata    <= 4'hF;
            r_anode      <= '1;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_state      <= w_state_nxt;
            r_active_dig <= w_active_dig_nxt;
            r_active_dp  <= w_active_dp_nxt;
            if (load) begin
                r_shadow_dig <= digits_in;
                r_shadow_dp  <= dp_in;
            end
            r_frame_done <= w_wrap;
            if (w_lit) begin
                r_anode   <= ~w_sel;
                r_bindata <= w_nib[w_idx_nxt];
                r_dp      <= ~w_active_dp_nxt[w_idx_nxt];
            end else begin
                r_anode   <= '1;
                r_bindata <= 4'hF;
                r_dp      <= 1'b1;
            end
        end
    end

    assign bindata    = r_bindata;
    assign anode      = r_anode;
    assign dp         = r_dp;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_ctrl
// Brief    : Self-checking bench for seg_scan_ctrl (LZ on and LZ off copies).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

    localparam int c_ND = 4;
    localparam int c_RD = 8;
    localparam int c_BC = 2;
    localparam int c_FRAME = c_ND * c_RD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;

    logic [3:0] bindata_lz, bindata_all, anode_lz, anode_all;
    logic       dp_lz, dp_all, fd_lz, fd_all;

    seg_scan_ctrl #(.NUM_DIGITS(c_ND), .REFRESH_DIV(c_RD), .BLANK_CYCLES(c_BC),
                    .LZ_SUPPRESS(1)) u_dut_lz (
        .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .load(load),
        .bindata(bindata_lz), .anode(anode_lz), .dp(dp_lz), .frame_done(fd_lz));

    seg_scan_ctrl #(.NUM_DIGITS(c_ND), .REFRESH_DIV(c_RD), .BLANK_CYCLES(c_BC),
                    .LZ_SUPPRESS(0)) u_dut_all (
        .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .load(load),
        .bindata(bindata_all), .anode(anode_all), .dp(dp_all), .frame_done(fd_all));

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: time since reset plus the shadow/active digit buffers.
    int          m_t = 0;
    logic [15:0] m_shadow = '0, m_active = '0;
    logic [3:0]  m_sdp = '0, m_adp = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t = 0; m_shadow = '0; m_active = '0; m_sdp = '0; m_adp = '0;
        end else begin
            if (m_t % c_FRAME == c_FRAME - 1) begin
                m_active = load ? digits_in : m_shadow;
                m_adp    = load ? dp_in : m_sdp;
            end
            if (load) begin
                m_shadow = digits_in;
                m_sdp    = dp_in;
            end
            m_t++;
        end
    end

    // Returns {anode, bindata, dp, frame_done} expected at model time t.
    function automatic logic [9:0] expect_out(input int t, input logic lz,
                                              input logic [15:0] act, input logic [3:0] adp);
        int cnt, idx;
        logic sup, fd;
        logic [3:0] an, bd;
        logic d;
        cnt = t % c_RD;
        idx = (t / c_RD) % c_ND;
        fd  = (t % c_FRAME == 0) && (t != 0);
        sup = 1'b0;
        if (lz && idx > 0) begin
            sup = 1'b1;
            for (int j = idx; j < c_ND; j++)
                if (act[4*j +: 4] != 4'h0 || adp[j]) sup = 1'b0;
        end
        an = 4'b1111; bd = 4'hF; d = 1'b1;
        if (cnt >= c_BC && !sup) begin
            an[idx] = 1'b0;
            bd = act[4*idx +: 4];
            d  = ~adp[idx];
        end
        return {an, bd, d, fd};
    endfunction

    always @(negedge clk) begin
        logic [9:0] e1, e0;
        e1 = expect_out(m_t, 1'b1, m_active, m_adp);
        e0 = expect_out(m_t, 1'b0, m_active, m_adp);
        n_vec++;
        if ({anode_lz, bindata_lz, dp_lz, fd_lz} !== e1) begin
            n_err++;
            $display("FAIL scan_lz t=%0d got=%b required=%b", m_t,
                     {anode_lz, bindata_lz, dp_lz, fd_lz}, e1);
        end
        n_vec++;
        if ({anode_all, bindata_all, dp_all, fd_all} !== e0) begin
            n_err++;
            $display("FAIL scan_all t=%0d got=%b required=%b", m_t,
                     {anode_all, bindata_all, dp_all, fd_all}, e0);
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h required=%h", nm, got, exp);
        end
    endtask

    task automatic chk_lz(input string nm, input logic [3:0] an, input logic [3:0] bd, input logic d);
        chk(nm, {23'd0, anode_lz, bindata_lz, dp_lz}, {23'd0, an, bd, d});
    endtask

    task automatic chk_all(input string nm, input logic [3:0] an, input logic [3:0] bd, input logic d);
        chk(nm, {23'd0, anode_all, bindata_all, dp_all}, {23'd0, an, bd, d});
    endtask

    task automatic wait_t(input int tt);
        int guard = 0;
        while (m_t != tt && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (m_t != tt) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_t reached=%0d required=%0d", m_t, tt);
        end
    endtask

    task automatic load_at(input int tt, input logic [15:0] d, input logic [3:0] p);
        wait_t(tt);
        digits_in = d;
        dp_in     = p;
        load      = 1'b1;
        @(negedge clk);
        load      = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_lz("reset_out", 4'b1111, 4'hF, 1'b1);
        chk("reset_fd", {31'd0, fd_lz}, 32'd0);
        rst = 1'b0;

        load_at(3, 16'h1234, 4'b0000);
        wait_t(32); chk("fd_t32", {31'd0, fd_lz}, 32'd1);
        wait_t(33); chk("fd_t33", {31'd0, fd_lz}, 32'd0);
        wait_t(34); chk_lz("f1_s0", 4'b1110, 4'h4, 1'b1);
        wait_t(39); chk_lz("f1_s0_end", 4'b1110, 4'h4, 1'b1);
        wait_t(40); chk_lz("f1_s1_blank0", 4'b1111, 4'hF, 1'b1);
        wait_t(41); chk_lz("f1_s1_blank1", 4'b1111, 4'hF, 1'b1);
        wait_t(42); chk_lz("f1_s1", 4'b1101, 4'h3, 1'b1);
        wait_t(50); chk_lz("f1_s2", 4'b1011, 4'h2, 1'b1);
        wait_t(58); chk_lz("f1_s3", 4'b0111, 4'h1, 1'b1);
        wait_t(63); chk("fd_t63", {31'd0, fd_lz}, 32'd0);
        wait_t(64); chk("fd_t64", {31'd0, fd_lz}, 32'd1);

        load_at(75, 16'h9999, 4'b0000);
        wait_t(82); chk_lz("tear_s2", 4'b1011, 4'h2, 1'b1);
        wait_t(90); chk_lz("tear_s3", 4'b0111, 4'h1, 1'b1);
        wait_t(98); chk_lz("new_s0", 4'b1110, 4'h9, 1'b1);

        load_at(100, 16'h5555, 4'b0000);
        load_at(110, 16'h0050, 4'b0000);
        wait_t(122); chk_lz("old_s3", 4'b0111, 4'h9, 1'b1);
        wait_t(130); chk_lz("lz50_s0", 4'b1110, 4'h0, 1'b1);
        wait_t(138); chk_lz("lz50_s1", 4'b1101, 4'h5, 1'b1);

        load_at(140, 16'h0000, 4'b0000);
        wait_t(146); chk_lz("lz50_s2", 4'b1111, 4'hF, 1'b1);
        chk_all("all50_s2", 4'b1011, 4'h0, 1'b1);
        wait_t(154); chk_lz("lz50_s3", 4'b1111, 4'hF, 1'b1);
        chk_all("all50_s3", 4'b0111, 4'h0, 1'b1);
        wait_t(162); chk_lz("lz0_s0", 4'b1110, 4'h0, 1'b1);
        wait_t(170); chk_lz("lz0_s1", 4'b1111, 4'hF, 1'b1);
        chk_all("all0_s1", 4'b1101, 4'h0, 1'b1);
        wait_t(178); chk_lz("lz0_s2", 4'b1111, 4'hF, 1'b1);

        load_at(191, 16'h0007, 4'b0010);
        wait_t(194); chk_lz("wrap_s0", 4'b1110, 4'h7, 1'b1);
        wait_t(200); chk_lz("wrap_s1_blank", 4'b1111, 4'hF, 1'b1);
        wait_t(202); chk_lz("wrap_s1_dp", 4'b1101, 4'h0, 1'b0);
        wait_t(210); chk_lz("wrap_s2", 4'b1111, 4'hF, 1'b1);

        load_at(212, 16'h00B0, 4'b0000);
        wait_t(226); chk_lz("hex_s0", 4'b1110, 4'h0, 1'b1);
        wait_t(234); chk_lz("hex_s1", 4'b1101, 4'hB, 1'b1);
        wait_t(236); chk_lz("hex_s1_mid", 4'b1101, 4'hB, 1'b1);

        #2 rst = 1'b1;
        #1;
        chk_lz("midrst_out", 4'b1111, 4'hF, 1'b1);
        chk("midrst_fd", {31'd0, fd_lz}, 32'd0);
        chk_all("midrst_all", 4'b1111, 4'hF, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        wait_t(1); chk_lz("rel_cnt1", 4'b1111, 4'hF, 1'b1);
        wait_t(2); chk_lz("rel_cnt2", 4'b1110, 4'h0, 1'b1);
        chk_all("rel_cnt2_all", 4'b1110, 4'h0, 1'b1);
        wait_t(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
